dot_product_accumulator: RTL and testbench
==========================================

Name: dot_product_accumulator

Overview:
- Consumes the registered 16-bit product stream from the 8x8 parallel multiplier stage. Each product arrives one cycle after its operands; the upstream controller delays the operand-valid strobe by one cycle to form in_valid.
- Sums LEN consecutive products into one dot-product result, with saturation and an overflow flag.
- Presents each result on a valid/ready output port, with one holding register, to the downstream consumer (requantiser or result FIFO).

Parameters:
- PROD_W, 16, product input width; matches the multiplier output.
- ACC_W, 24, accumulator and result width; must be >= PROD_W.
- LEN, 8, products per dot product; must be >= 1.
- CNT_W, 3, element counter width; must satisfy 2^CNT_W >= LEN.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- rst, input, 1, asynchronous active-low reset.
- in_data, input, PROD_W, unsigned product.
- in_valid, input, 1, in_data is valid this cycle.
- in_ready, output, 1, block accepts in_data this cycle.
- clear, input, 1, synchronous abort of the partial accumulation.
- out_data, output, ACC_W, completed dot-product sum.
- out_ovf, output, 1, saturation occurred during this result.
- out_valid, output, 1, out_data and out_ovf are valid.
- out_ready, input, 1, consumer accepts the result.

Behaviour:
Reset:
- rst low, asynchronous: acc=0, cnt=0, ovf_acc=0, out_data=0, out_ovf=0, out_valid=0.
- Release is synchronous to clk in the surrounding design. No special deassertion handling inside the block.
- Reset mid-vector discards the partial sum and any pending result.

Handshake:
- in_ready = !out_valid || out_ready. This is combinational and needs no bubble.
- The input transfer (acc_fire) is in_valid && in_ready.
- The output transfer is out_valid && out_ready.
- out_data and out_ovf hold stable while out_valid=1 and out_ready=0.

Arithmetic:
- sum = acc + zero-extended in_data, computed at ACC_W+1 bits.
- If the carry bit is set: the result is clamped to 2^ACC_W-1 and the overflow term is 1.
- After saturation, the clamp holds for the remainder of the vector: saturated acc plus any nonzero product stays at the maximum.
- ovf_acc is sticky across the vector.

Per cycle, in priority order:
1. clear=1: acc<=0, cnt<=0, ovf_acc<=0. Any input offered this cycle is accepted and dropped (in_ready unchanged). A pending output is unaffected.
2. acc_fire and cnt != LEN-1: acc<=sat(sum), ovf_acc<=ovf_acc|carry, cnt<=cnt+1.
3. acc_fire and cnt == LEN-1 (completion):
   - out_data<=sat(sum), out_ovf<=ovf_acc|carry, out_valid<=1.
   - acc<=0, cnt<=0, ovf_acc<=0.
4. Otherwise, an output transfer with no completion: out_valid<=0.

Timing and boundary rules:
- Latency: out_valid rises the cycle after the LEN-th product is accepted.
- Simultaneous output transfer and completion in one cycle: out_valid stays 1 and out_data takes the new result.
- Consequence: sustained throughput is one product per cycle with out_ready held high. This includes LEN=1, where every accepted product becomes a result.
- Backpressure: out_valid=1 with out_ready=0 forces in_ready=0. acc and cnt freeze and no product is lost.
- cnt wraps from LEN-1 to 0 only on completion and never reaches LEN.
- in_data is ignored when in_valid=0.

Test Plan:
1. Reset, then LEN=4, ACC_W=24. Feed 100,200,300,400 back-to-back with out_ready=1 -> one cycle after the 4th acceptance: out_valid=1, out_data=1000, out_ovf=0. out_valid drops the next cycle.
2. LEN=4. Feed 65025 four times -> out_data=260100, out_ovf=0. Immediately feed 1,1,1,1 with no gap -> second result out_data=4. This confirms the accumulator clears at completion.
3. Overflow, ACC_W=17, LEN=4. Feed 65025 x4 -> out_data=131071, out_ovf=1. Next vector 1,2,3,4 -> out_data=10, out_ovf=0.
4. Backpressure. Hold out_ready=0 after result 1000 is produced -> in_ready=0. in_valid=1 with data 7 is not consumed, and out_data holds 1000 for 5 cycles. Raise out_ready -> the 7 is accepted in the same cycle as the output transfer and becomes the first element of the next vector.
5. Feed 10,20, then pulse clear with in_valid=0, then feed 1,2,3,4 -> out_data=10, not 40. Assert clear while a result is pending -> out_valid and out_data are unchanged.
6. Feed 5,6, then assert rst low asynchronously mid-cycle -> out_valid=0 and out_data=0 immediately. After release, feed 1,1,1,1 -> out_data=4.

Source files
------------

// File: rtl/dot_product_accumulator.sv
// Sums LEN consecutive unsigned products into a saturating dot-product result
// and hands each result downstream through a single valid/ready holding register.
module dot_product_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN    = 8,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clear,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_acc;

  logic             acc_fire;
  logic             out_fire;
  logic             last;
  logic             carry;
  logic             complete;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] sat_sum;

  // The holding register frees up in the same cycle it is drained, so no bubble.
  assign in_ready = !out_valid || out_ready;
  assign acc_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last     = (cnt == LAST);
  assign complete = acc_fire && !clear && last;

  assign sum     = {1'b0, acc} + (ACC_W + 1)'(in_data);
  assign carry   = sum[ACC_W];
  assign sat_sum = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else if (clear || (acc_fire && last)) begin
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else if (acc_fire) begin
      acc     <= sat_sum;
      ovf_acc <= ovf_acc | carry;
      cnt     <= cnt + CNT_W'(1);
    end
  end

  // A completion landing on a drain cycle refills the register without dropping valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (complete) begin
      out_data  <= sat_sum;
      out_ovf   <= ovf_acc | carry;
      out_valid <= 1'b1;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Drives two LEN=4 accumulators (24-bit and 17-bit) with identical streams and
// checks both against a queue-based scoreboard fed by a saturating-sum model.
module tb_dot_product_accumulator;

  localparam int LEN = 4;

  typedef struct {
    longint unsigned d24;
    bit              o24;
    longint unsigned d17;
    bit              o17;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        clear;
  logic        out_ready;

  logic [23:0] d24_out_data;
  logic        d24_out_ovf;
  logic        d24_out_valid;
  logic        d24_in_ready;
  logic [16:0] d17_out_data;
  logic        d17_out_ovf;
  logic        d17_out_valid;
  logic        d17_in_ready;

  int errors = 0;
  int checks = 0;

  longint unsigned vec[$];
  exp_t            exp_q[$];
  bit              pending = 1'b0;
  exp_t            mon_e;

  dot_product_accumulator #(.PROD_W(16), .ACC_W(24), .LEN(LEN), .CNT_W(2)) dut24 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(d24_in_ready),
    .clear(clear), .out_data(d24_out_data), .out_ovf(d24_out_ovf),
    .out_valid(d24_out_valid), .out_ready(out_ready)
  );

  dot_product_accumulator #(.PROD_W(16), .ACC_W(17), .LEN(LEN), .CNT_W(2)) dut17 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(d17_in_ready),
    .clear(clear), .out_data(d17_out_data), .out_ovf(d17_out_ovf),
    .out_valid(d17_out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint unsigned actual,
                             input longint unsigned expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and are stable across the next one.
  task automatic applyStimulus(input bit v, input logic [15:0] d, input bit c, input bit r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    clear     = c;
    out_ready = r;
  endtask

  task automatic feedVector(input longint unsigned a, input longint unsigned b,
                            input longint unsigned c, input longint unsigned d, input bit r);
    applyStimulus(1'b1, 16'(a), 1'b0, r);
    applyStimulus(1'b1, 16'(b), 1'b0, r);
    applyStimulus(1'b1, 16'(c), 1'b0, r);
    applyStimulus(1'b1, 16'(d), 1'b0, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
  endtask

  function automatic longint unsigned satDot(input int width, output bit ovf);
    longint unsigned maxv = (64'd1 << width) - 1;
    longint unsigned s = 0;
    ovf = 1'b0;
    foreach (vec[i]) begin
      s = s + vec[i];
      if (s > maxv) begin
        s   = maxv;
        ovf = 1'b1;
      end
    end
    return s;
  endfunction

  // Reference model: predicts handshake and collects each vector's products.
  always @(negedge clk) begin
    bit   ready_exp;
    bit   fire;
    bit   done;
    exp_t e;
    if (!rst) begin
      vec.delete();
      exp_q.delete();
      pending = 1'b0;
    end else begin
      ready_exp = !pending || out_ready;
      checkOutput("in_ready24", d24_in_ready, ready_exp);
      checkOutput("in_ready17", d17_in_ready, ready_exp);
      checkOutput("out_valid24", d24_out_valid, pending);
      checkOutput("out_valid17", d17_out_valid, pending);
      fire = in_valid && ready_exp;
      done = 1'b0;
      if (clear) begin
        vec.delete();
      end else if (fire) begin
        vec.push_back(longint'(in_data));
        if (vec.size() == LEN) begin
          e.d24 = satDot(24, e.o24);
          e.d17 = satDot(17, e.o17);
          exp_q.push_back(e);
          vec.delete();
          done = 1'b1;
        end
      end
      if (done) pending = 1'b1;
      else if (pending && out_ready) pending = 1'b0;
    end
  end

  // Monitor: compares every presented result with the oldest expected one.
  always @(negedge clk) begin
    if (rst && d24_out_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out", 1, 0);
      end else begin
        mon_e = exp_q[0];
        checkOutput("out_data24", d24_out_data, mon_e.d24);
        checkOutput("out_ovf24", d24_out_ovf, mon_e.o24);
        checkOutput("out_data17", d17_out_data, mon_e.d17);
        checkOutput("out_ovf17", d17_out_ovf, mon_e.o17);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'd0;
    clear     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", d24_out_valid, 0);
    checkOutput("rst_data", d24_out_data, 0);
    checkOutput("rst_ovf", d24_out_ovf, 0);
    checkOutput("rst_ready", d24_in_ready, 1);
    rst = 1'b1;

    // Back-to-back vectors, including one saturating the narrow accumulator.
    feedVector(100, 200, 300, 400, 1'b1);
    idle(3);
    feedVector(65025, 65025, 65025, 65025, 1'b1);
    feedVector(1, 1, 1, 1, 1'b1);
    feedVector(1, 2, 3, 4, 1'b1);
    idle(3);

    // Backpressure: result held, the stalled 7 starts the next vector.
    feedVector(100, 200, 300, 400, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'd7, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd7, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'd8, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'd9, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'd10, 1'b0, 1'b1);
    idle(3);

    // Clear aborts a partial vector and leaves a pending result alone.
    applyStimulus(1'b1, 16'd10, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'd20, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
    feedVector(1, 2, 3, 4, 1'b1);
    idle(2);
    applyStimulus(1'b1, 16'd500, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'd50, 1'b1, 1'b0);
    feedVector(1, 2, 3, 4, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
    idle(3);

    // Asynchronous reset in the middle of a vector and of a pending result.
    feedVector(9, 9, 9, 9, 1'b0);
    applyStimulus(1'b1, 16'd5, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd6, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("async_valid24", d24_out_valid, 0);
    checkOutput("async_data24", d24_out_data, 0);
    checkOutput("async_valid17", d17_out_valid, 0);
    checkOutput("async_data17", d17_out_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    feedVector(1, 1, 1, 1, 1'b1);
    idle(3);

    // Randomised traffic; clear only ever coincides with out_ready low.
    for (int i = 0; i < 400; i++) begin
      bit              v;
      bit              c;
      bit              r;
      longint unsigned d;
      v = ($urandom_range(9, 0) < 7);
      r = ($urandom_range(3, 0) != 0);
      c = ($urandom_range(29, 0) == 0);
      if (c) r = 1'b0;
      d = ($urandom_range(1, 0) == 1) ? longint'($urandom_range(65535, 60000))
                                      : longint'($urandom_range(3000, 0));
      applyStimulus(v, 16'(d), c, r);
    end
    idle(6);
    @(negedge clk);
    checkOutput("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
